// File: rtl/i2c_register_bridge.sv
`default_nettype none
// ============================================================================
// Module   : i2c_register_bridge
// Summary  : Maps I2C slave byte-engine strobes onto a NUM_REGS x 8-bit
//            register bank. The first written byte sets the pointer. Later
//            bytes write the register at the pointer. Reads return the
//            register at the pointer. Stall holds SCL so that tx data is
//            settled before it is released.
// Options  : `define I2C_REGISTER_BRIDGE_AUTOINC_EN makes the pointer
//            auto-increment after each data byte that is written or read.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_register_bridge #(
  parameter logic [6:0]          I2C_ADDRESS = 7'h42,
  parameter int                  NUM_REGS    = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i2c_addr_rw,
  input  logic                  i2c_addr_rw_valid_stb,
  input  logic [7:0]            i2c_data_rx,
  input  logic                  i2c_data_rx_valid_stb,
  output logic [7:0]            i2c_data_tx,
  input  logic                  i2c_data_tx_loaded_stb,
  input  logic                  i2c_data_tx_done_stb,
  input  logic                  i2c_error_stb,
  output logic                  stall,
  input  logic [8*NUM_REGS-1:0] reg_in,
  output logic [8*NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0]   reg_wr_stb
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PTR   = 2'd1,
    S_WRITE = 2'd2,
    S_READ  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       ptr, ptr_nxt;
  logic             wr_en;
  logic             ptr_upd;
  logic             in_range;
  logic             addr_match;
  logic [IDX_W-1:0] idx;
  logic [7:0]       rdval;

  // The done strobe carries no information this bridge needs.
  logic unused_done;
  assign unused_done = i2c_data_tx_done_stb;

  assign in_range   = ({1'b0, ptr} < 9'(NUM_REGS));
  assign idx        = ptr[IDX_W-1:0];
  assign addr_match = (i2c_addr_rw[7:1] == I2C_ADDRESS);

`ifdef I2C_REGISTER_BRIDGE_AUTOINC_EN
  logic [7:0] ptr_inc;
  // Wrap to zero from the last register or from any out-of-range pointer.
  assign ptr_inc = (in_range && (({1'b0, ptr} + 9'd1) < 9'(NUM_REGS))) ? (ptr + 8'd1) : 8'h00;
`endif

  // Next-state, pointer and write-enable decode; error beats addr beats data.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    wr_en     = 1'b0;
    ptr_upd   = 1'b0;
    if (i2c_error_stb) begin
      state_nxt = S_IDLE;
    end else if (i2c_addr_rw_valid_stb) begin
      if (!addr_match)         state_nxt = S_IDLE;
      else if (i2c_addr_rw[0]) state_nxt = S_READ;
      else                     state_nxt = S_PTR;
    end else if (i2c_data_rx_valid_stb && (state == S_PTR)) begin
      ptr_nxt   = i2c_data_rx;
      state_nxt = S_WRITE;
      ptr_upd   = 1'b1;
    end else if (i2c_data_rx_valid_stb && (state == S_WRITE)) begin
      wr_en   = in_range && !RO_MASK[idx];
      ptr_upd = 1'b1;
`ifdef I2C_REGISTER_BRIDGE_AUTOINC_EN
      ptr_nxt = ptr_inc;
`endif
    end else if (i2c_data_tx_loaded_stb && (state == S_READ)) begin
      ptr_upd = 1'b1;
`ifdef I2C_REGISTER_BRIDGE_AUTOINC_EN
      ptr_nxt = ptr_inc;
`endif
    end
  end

  // Read mux: out-of-range reads return 0xFF; read-only regs come from fabric.
  always_comb begin
    rdval = 8'hFF;
    if (in_range) begin
      if (RO_MASK[idx]) rdval = reg_in[{idx, 3'b000} +: 8];
      else              rdval = reg_out[{idx, 3'b000} +: 8];
    end
  end

  // State, pointer, tx data and stall; stall covers the cycle tx data needs to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= 8'h00;
      i2c_data_tx <= 8'h00;
      stall       <= 1'b1;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      i2c_data_tx <= rdval;
      stall       <= ptr_upd | wr_en;
    end
  end

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      // Per-register storage and one-cycle write strobe.
      always_ff @(posedge clk) begin
        if (rst) begin
          reg_out[8*i +: 8] <= 8'h00;
          reg_wr_stb[i]     <= 1'b0;
        end else begin
          reg_wr_stb[i] <= wr_en && (idx == IDX_W'(i));
          if (wr_en && (idx == IDX_W'(i))) reg_out[8*i +: 8] <= i2c_data_rx;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_i2c_register_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_register_bridge
// Summary  : Self-checking bench for i2c_register_bridge (address 0x42,
//            8 registers, register 7 read-only). Runs directed scenarios
//            followed by random strobe traffic, and checks the DUT against
//            a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_register_bridge;

`ifdef I2C_REGISTER_BRIDGE_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam logic [7:0] RO = 8'h80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i2c_addr_rw = '0;
  logic        i2c_addr_rw_valid_stb = 1'b0;
  logic [7:0]  i2c_data_rx = '0;
  logic        i2c_data_rx_valid_stb = 1'b0;
  logic [7:0]  i2c_data_tx;
  logic        i2c_data_tx_loaded_stb = 1'b0;
  logic        i2c_data_tx_done_stb = 1'b0;
  logic        i2c_error_stb = 1'b0;
  logic        stall;
  logic [63:0] reg_in = '0;
  logic [63:0] reg_out;
  logic [7:0]  reg_wr_stb;

  int checks = 0;
  int errors = 0;

  // Reference model: a bank of values, a pointer, and the current transaction phase.
  logic [7:0] mregs [8];
  logic [7:0] mptr;
  int         mode;   // 0 none, 1 awaiting pointer, 2 writing data, 3 reading data

  i2c_register_bridge #(
    .I2C_ADDRESS(7'h42),
    .NUM_REGS   (8),
    .RO_MASK    (8'h80)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .i2c_addr_rw           (i2c_addr_rw),
    .i2c_addr_rw_valid_stb (i2c_addr_rw_valid_stb),
    .i2c_data_rx           (i2c_data_rx),
    .i2c_data_rx_valid_stb (i2c_data_rx_valid_stb),
    .i2c_data_tx           (i2c_data_tx),
    .i2c_data_tx_loaded_stb(i2c_data_tx_loaded_stb),
    .i2c_data_tx_done_stb  (i2c_data_tx_done_stb),
    .i2c_error_stb         (i2c_error_stb),
    .stall                 (stall),
    .reg_in                (reg_in),
    .reg_out               (reg_out),
    .reg_wr_stb            (reg_wr_stb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_rd();
    if (mptr >= 8)    return 8'hFF;
    else if (RO[mptr]) return reg_in[8*mptr +: 8];
    else              return mregs[mptr];
  endfunction

  function automatic logic [63:0] model_regs();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mregs[i];
    return v;
  endfunction

  function automatic logic [7:0] next_ptr(input logic [7:0] p);
    return (int'(p) + 1 < 8) ? p + 8'd1 : 8'h00;
  endfunction

  // Reset the DUT and the model, then check the reset values and the stall release.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    mptr = 8'h00; mode = 0;
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    check("rst_reg_out", reg_out, 64'h0);
    check("rst_wr_stb", reg_wr_stb, 8'h00);
    check("rst_tx", i2c_data_tx, 8'h00);
    check("rst_stall", stall, 1'b1);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_stall_release", stall, 1'b0);
    check("rst_tx_after", i2c_data_tx, model_rd());
  endtask

  // One strobe cycle, with the caller at a negedge; it checks the write/stall cycle, then the settled tx.
  task automatic step(input bit a_s, input logic [7:0] a, input bit r_s, input logic [7:0] r,
                      input bit t_s, input bit e_s);
    logic [7:0] ewr;
    bit         evt;
    ewr = 8'h00; evt = 1'b0;
    i2c_addr_rw = a;  i2c_addr_rw_valid_stb = a_s;
    i2c_data_rx = r;  i2c_data_rx_valid_stb = r_s;
    i2c_data_tx_loaded_stb = t_s; i2c_error_stb = e_s;
    if (e_s) mode = 0;
    else if (a_s) mode = (a[7:1] != 7'h42) ? 0 : (a[0] ? 3 : 1);
    else if (r_s && mode == 1) begin mptr = r; mode = 2; evt = 1'b1; end
    else if (r_s && mode == 2) begin
      if (mptr < 8 && !RO[mptr]) begin mregs[mptr] = r; ewr = 8'h01 << mptr; end
      if (AUTO) mptr = next_ptr(mptr);
      evt = 1'b1;
    end else if (t_s && mode == 3) begin
      if (AUTO) mptr = next_ptr(mptr);
      evt = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    i2c_addr_rw_valid_stb = 1'b0; i2c_data_rx_valid_stb = 1'b0;
    i2c_data_tx_loaded_stb = 1'b0; i2c_error_stb = 1'b0;
    check("wr_stb", reg_wr_stb, ewr);
    check("stall_pulse", stall, evt);
    check("reg_out", reg_out, model_regs());
    @(posedge clk); @(negedge clk);
    check("tx_data", i2c_data_tx, model_rd());
    check("stall_idle", stall, 1'b0);
    check("wr_stb_idle", reg_wr_stb, 8'h00);
  endtask

  task automatic addr(input logic [7:0] a); step(1, a, 0, 8'h00, 0, 0); endtask
  task automatic rx(input logic [7:0] r);   step(0, 8'h00, 1, r, 0, 0);  endtask
  task automatic txl();                     step(0, 8'h00, 0, 8'h00, 1, 0); endtask
  task automatic err();                     step(0, 8'h00, 0, 8'h00, 0, 1); endtask

  initial begin
    int op;
    logic [7:0] rv;
    do_reset();

    // Burst write with pointer set.
    addr(8'h84); rx(8'h03); rx(8'hAA); rx(8'h55);
    // Pointer set, then repeated-start read across the wrap.
    addr(8'h84); rx(8'h06); addr(8'h85); txl(); txl();
    // Foreign address: nothing is written.
    addr(8'h90); rx(8'h11);
    // Read-only register: write dropped, read returns fabric value.
    reg_in[63:56] = 8'h5A;
    addr(8'h84); rx(8'h07); rx(8'hFF);
    addr(8'h84); rx(8'h07); addr(8'h85);
    // Out-of-range pointer, then error mid-write.
    addr(8'h84); rx(8'h14); addr(8'h85);
    addr(8'h84); rx(8'h14); rx(8'h33);
    addr(8'h84); rx(8'h01); rx(8'h77); err(); rx(8'h44);
    // Same-cycle priority: addr beats rx, error beats all.
    addr(8'h84); step(1, 8'h84, 1, 8'h02, 0, 0); rx(8'h05);
    step(1, 8'h85, 1, 8'h66, 1, 1); rx(8'h99);
    // Reset mid-burst, then a short burst.
    addr(8'h84); rx(8'h02); rx(8'h12);
    do_reset();
    addr(8'h84); rx(8'h02); rx(8'hAA); rx(8'hBB);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) reg_in = {$urandom, $urandom};
      op = $urandom_range(0, 19);
      rv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      if (op == 0)       do_reset();
      else if (op < 4)   addr(($urandom_range(0, 7) == 0) ? 8'($urandom) : {7'h42, 1'($urandom)});
      else if (op < 11)  rx(rv);
      else if (op < 16)  txl();
      else if (op == 16) err();
      else step(1'($urandom), {7'h42, 1'($urandom)}, 1'($urandom), rv, 1'($urandom), 1'($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
